zero_scan_ctrl: RTL and testbench
=================================

# zero_scan_ctrl

Sequencing controller that walks a block of 8-bit words held in a synchronous-read memory and feeds each word, one at a time, through a single internal `zeroDetector` instance (`a` in, `y` = 1 when `a` == 0). It counts the zero words and records the index of the first non-zero word. It can optionally stop at the first non-zero word. It sits beside the register file and scratch memory as the zero/compare helper the processor control path uses for block-clear checks and branch-on-zero-block.

## Interface
- `WIDTH`, 8: data word width; must match the `zeroDetector` port width.
- `DEPTH`, 16: maximum words per scan.
- `ADDR_W`, 4: memory address width; DEPTH = 2^ADDR_W.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `len`  in  ADDR_W+1  number of words to scan, starting at address 0; latched on accept.
- `stop_on_nz`  in  1  1 = end the scan at the first non-zero word; latched on accept.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_data`  in  WIDTH  read data, valid the cycle after `mem_en`.
- `busy`  out  1  high in FETCH and CHECK.
- `done`  out  1  one-cycle completion pulse.
- `zero_count`  out  ADDR_W+1  number of zero words seen.
- `found_nz`  out  1  at least one non-zero word seen.
- `first_nz_idx`  out  ADDR_W  index of the first non-zero word; 0 if none.
- `all_zero`  out  1  registered copy of !`found_nz`, valid with `done`.

## Operation
- States are IDLE, FETCH, CHECK and DONE.
- **IDLE, `start`=1:**
  - Latch `len` (values above DEPTH are clamped to DEPTH) and `stop_on_nz`.
  - Clear `zero_count`, `found_nz`, `first_nz_idx` and `all_zero`. Set idx to 0.
  - If the clamped len is 0, go to DONE. Otherwise go to FETCH.
- **IDLE, `start`=0:** stay in IDLE. Results hold their last values.
- **FETCH:**
  - Drive `mem_en`=1 and `mem_addr`=idx.
  - Next state is always CHECK.
- **CHECK:**
  - `mem_data` drives `zeroDetector.a`.
  - If `y`=1, increment `zero_count`.
  - If `y`=0 and `found_nz`=0, set `found_nz`<=1 and `first_nz_idx`<=idx.
  - If idx == len-1, go to DONE.
  - Else if `stop_on_nz` && `y`=0, go to DONE.
  - Otherwise idx<=idx+1 and go to FETCH.
- **DONE:**
  - `done`=1 and `busy`=0.
  - `all_zero`<=!`found_nz`, taking the value as updated in the final CHECK.
  - Next state is always IDLE.
- `start` is ignored in FETCH, CHECK and DONE. It is not queued.
- Arithmetic rules:
  - idx is ADDR_W+1 bits wide and never exceeds DEPTH-1.
  - `zero_count` is at most DEPTH, so it never wraps.
- Results (`zero_count`, `found_nz`, `first_nz_idx`, `all_zero`) are stable from the `done` cycle until the next accepted `start`.

## Timing
- **Reset:**
  - State goes to IDLE.
  - `mem_en`, `mem_addr`, `busy`, `done`, `zero_count`, `found_nz`, `first_nz_idx` and `all_zero` all go to 0.
  - Reset mid-scan aborts immediately, with no `done` pulse.
- **Outputs:** all are registered or decoded from state only. There is no combinational path from `start` to any output.
- **Full scan:** with `start` sampled at edge 0, FETCH for word k occupies cycle 2k+1 and CHECK for word k occupies cycle 2k+2. `done` is high in cycle 2·len+1.
- **Early stop at word k:** `done` is high in cycle 2k+3.
- **len=0:** `done` is high in cycle 1. Results are `zero_count`=0, `found_nz`=0, `all_zero`=1.
- **Restart:** the earliest next accept is IDLE in cycle `done`+1, giving back-to-back scans with one idle cycle between them.
- **Memory:** `mem_en` is high only in FETCH, so there is exactly one read per word.

## Test plan
- **All-zero block:** len=4, mem={0,0,0,0} -> `done` in cycle 9, `zero_count`=4, `found_nz`=0, `all_zero`=1.
- **Full scan with non-zero words:** len=4, mem={0,0,8'h33,0}, `stop_on_nz`=0 -> `done` in cycle 9, `zero_count`=3, `found_nz`=1, `first_nz_idx`=2, `all_zero`=0.
- **Early stop:** same data with `stop_on_nz`=1 -> `done` in cycle 7, `zero_count`=2, `first_nz_idx`=2, exactly 3 `mem_en` pulses.
- **Zero length and clamp:**
  - len=0 -> `done` in cycle 1, `all_zero`=1, no `mem_en`.
  - len=17 with DEPTH=16 -> 16 reads (addresses 0..15), `done` in cycle 33.
- **Ignored start:** pulse `start` during FETCH/CHECK and in the `done` cycle -> ignored, results unchanged. A `start` one cycle after `done` is accepted.
- **Reset mid-scan:** assert `rst` during CHECK of word 1 -> all outputs 0 asynchronously, no `done`. After release, a new scan of len=1, mem={8'h33} -> `zero_count`=0, `found_nz`=1, `first_nz_idx`=0.

Source files
------------

// File: rtl/zero_scan_ctrl.sv
// rtl/zero_scan_ctrl.sv - zero-word scan controller over a synchronous-read block memory
//
// Purpose:
//    Walks words 0..len-1 of a synchronous-read memory, one word at a time.
//    Each word is passed through a single zeroDetector instance.
//    Counts the zero words and records the index of the first non-zero word.
//    Can optionally end the scan at the first non-zero word.
//    Each word takes two cycles: FETCH issues the read, CHECK consumes the data.
//
// Ports:
//    clk_i           in   clock; all state updates on its rising edge
//    rst_i           in   asynchronous active-high reset
//    start_i         in   scan request, sampled only in IDLE
//    len_i           in   words to scan from address 0 (clamped to DEPTH)
//    stop_on_nz_i    in   end the scan at the first non-zero word
//    mem_en_o        out  memory read enable (FETCH only)
//    mem_addr_o      out  memory read address
//    mem_data_i      in   read data, valid the cycle after mem_en_o
//    busy_o          out  high in FETCH and CHECK
//    done_o          out  one-cycle completion pulse
//    zero_count_o    out  number of zero words seen
//    found_nz_o      out  at least one non-zero word seen
//    first_nz_idx_o  out  index of the first non-zero word, 0 if none
//    all_zero_o      out  registered !found_nz_o, valid with done_o

module zeroDetector #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   output logic             y_o
);

   assign y_o = (a_i == '0);

endmodule

module zero_scan_ctrl #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W:0]   len_i,
   input  logic              stop_on_nz_i,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [WIDTH-1:0]  mem_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   zero_count_o,
   output logic              found_nz_o,
   output logic [ADDR_W-1:0] first_nz_idx_o,
   output logic              all_zero_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

   state_t state_q, state_d;

   logic [ADDR_W:0]   idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              stop_q, stop_d;
   logic [ADDR_W:0]   zero_count_q, zero_count_d;
   logic              found_nz_q, found_nz_d;
   logic [ADDR_W-1:0] first_nz_idx_q, first_nz_idx_d;
   logic              all_zero_q, all_zero_d;

   logic [ADDR_W:0]   len_clamped;
   logic              word_zero;
   logic              last_word;
   logic              stop_now;

   zeroDetector #(
      .WIDTH (WIDTH)
   ) u_zero_det (
      .a_i (mem_data_i),
      .y_o (word_zero)
   );

   assign len_clamped = (len_i > DEPTH_L) ? DEPTH_L : len_i;

   // len_q is never 0 while scanning (len 0 goes straight to DONE),
   // so len_q - 1 cannot underflow here.
   assign last_word = (idx_q == (len_q - ONE_L));
   assign stop_now  = last_word || (stop_q && !word_zero);

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = (len_clamped == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d = stop_now ? ST_DONE : ST_FETCH;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs decoded from state
   // ---------------------------------------------------------------
   always_comb begin
      mem_en_o   = 1'b0;
      mem_addr_o = '0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_en_o   = 1'b1;
            mem_addr_o = idx_q[ADDR_W-1:0];
            busy_o     = 1'b1;
         end
         ST_CHECK: begin
            busy_o = 1'b1;
         end
         ST_DONE: begin
            done_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------
   always_comb begin
      idx_d          = idx_q;
      len_d          = len_q;
      stop_d         = stop_q;
      zero_count_d   = zero_count_q;
      found_nz_d     = found_nz_q;
      first_nz_idx_d = first_nz_idx_q;
      all_zero_d     = all_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d          = len_clamped;
               stop_d         = stop_on_nz_i;
               idx_d          = '0;
               zero_count_d   = '0;
               found_nz_d     = 1'b0;
               first_nz_idx_d = '0;
               all_zero_d     = 1'b0;
            end
         end
         ST_CHECK: begin
            if (word_zero) begin
               // At most DEPTH checks per scan, so this never wraps.
               zero_count_d = zero_count_q + ONE_L;
            end else if (!found_nz_q) begin
               found_nz_d     = 1'b1;
               first_nz_idx_d = idx_q[ADDR_W-1:0];
            end
            if (!stop_now) begin
               idx_d = idx_q + ONE_L;
            end
         end
         ST_DONE: begin
            all_zero_d = !found_nz_q;
         end
         default: begin
         end
      endcase

      // Resolve the all-zero verdict on the way into DONE, using the
      // found flag as updated by the final CHECK, so all_zero_o is
      // already correct in the done cycle (including the len 0 case).
      if (state_q != ST_DONE && state_d == ST_DONE) begin
         all_zero_d = !found_nz_d;
      end
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q          <= '0;
         len_q          <= '0;
         stop_q         <= 1'b0;
         zero_count_q   <= '0;
         found_nz_q     <= 1'b0;
         first_nz_idx_q <= '0;
         all_zero_q     <= 1'b0;
      end else begin
         idx_q          <= idx_d;
         len_q          <= len_d;
         stop_q         <= stop_d;
         zero_count_q   <= zero_count_d;
         found_nz_q     <= found_nz_d;
         first_nz_idx_q <= first_nz_idx_d;
         all_zero_q     <= all_zero_d;
      end
   end

   assign zero_count_o   = zero_count_q;
   assign found_nz_o     = found_nz_q;
   assign first_nz_idx_o = first_nz_idx_q;
   assign all_zero_o     = all_zero_q;

endmodule

// File: tb/tb_zero_scan_ctrl.sv
// tb/tb_zero_scan_ctrl.sv - directed vector bench for zero_scan_ctrl

module tb_zero_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] len;
   logic       stop;
   logic       mem_en;
   logic [3:0] mem_addr;
   logic [7:0] mem_data;
   logic       busy;
   logic       done;
   logic [4:0] zero_count;
   logic       found_nz;
   logic [3:0] first_nz_idx;
   logic       all_zero;

   logic [127:0] cur_data;

   int checks;
   int errors;

   typedef struct {
      logic [4:0]   len;
      logic         stop;
      logic [127:0] data;
      bit           hammer;
      bit           b2b;
      int           exp_done;
      int           exp_reads;
      int           exp_zc;
      int           exp_found;
      int           exp_idx;
      int           exp_az;
   } vec_t;

   vec_t vecs [11];
   vec_t v_after_rst;

   zero_scan_ctrl #(
      .WIDTH  (8),
      .DEPTH  (16),
      .ADDR_W (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .len_i          (len),
      .stop_on_nz_i   (stop),
      .mem_en_o       (mem_en),
      .mem_addr_o     (mem_addr),
      .mem_data_i     (mem_data),
      .busy_o         (busy),
      .done_o         (done),
      .zero_count_o   (zero_count),
      .found_nz_o     (found_nz),
      .first_nz_idx_o (first_nz_idx),
      .all_zero_o     (all_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory model: data appears the cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) mem_data <= cur_data[mem_addr*8 +: 8];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int dcyc;
      int reads;
      int aerr;
      cur_data = v.data;
      if (!v.b2b) @(negedge clk);
      start = 1'b1;
      len   = v.len;
      stop  = v.stop;
      dcyc  = -1;
      reads = 0;
      aerr  = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         start = v.hammer;
         if (mem_en) begin
            if (mem_addr != 4'(reads)) aerr++;
            reads++;
         end
         if (done) begin
            dcyc = c;
            break;
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_done_cycle", n), dcyc, v.exp_done);
      chk($sformatf("v%0d_reads", n), reads, v.exp_reads);
      chk($sformatf("v%0d_addr_errs", n), aerr, 0);
      chk($sformatf("v%0d_zero_count", n), int'(zero_count), v.exp_zc);
      chk($sformatf("v%0d_found_nz", n), int'(found_nz), v.exp_found);
      chk($sformatf("v%0d_first_nz_idx", n), int'(first_nz_idx), v.exp_idx);
      chk($sformatf("v%0d_all_zero", n), int'(all_zero), v.exp_az);
      if (v.hammer) begin
         @(negedge clk);
         chk($sformatf("v%0d_idle_after_ignored_start", n), int'({busy, mem_en}), 0);
         chk($sformatf("v%0d_zero_count_held", n), int'(zero_count), v.exp_zc);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      len      = '0;
      stop     = 1'b0;
      cur_data = '0;

      //           len    stop  data                                  ham b2b done rd  zc f idx az
      vecs[0]  = '{5'd4,  1'b0, 128'h0,                               1, 0,  9,  4,  4, 0, 0, 1};
      vecs[1]  = '{5'd4,  1'b0, 128'h0033_0000,                       0, 0,  9,  4,  3, 1, 2, 0};
      vecs[2]  = '{5'd4,  1'b1, 128'h0033_0000,                       0, 1,  7,  3,  2, 1, 2, 0};
      vecs[3]  = '{5'd0,  1'b0, 128'h0,                               0, 0,  1,  0,  0, 0, 0, 1};
      vecs[4]  = '{5'd17, 1'b0, 128'h0,                               0, 0, 33, 16, 16, 0, 0, 1};
      vecs[5]  = '{5'd16, 1'b0, (128'h80 << 72) | (128'h01 << 40),    0, 0, 33, 16, 14, 1, 5, 0};
      vecs[6]  = '{5'd16, 1'b1, (128'h80 << 72) | (128'h01 << 40),    0, 0, 13,  6,  5, 1, 5, 0};
      vecs[7]  = '{5'd31, 1'b1, 128'hC3,                              0, 0,  3,  1,  0, 1, 0, 0};
      vecs[8]  = '{5'd3,  1'b1, 128'h0,                               0, 0,  7,  3,  3, 0, 0, 1};
      vecs[9]  = '{5'd5,  1'b1, 128'h5A << 32,                        0, 0, 11,  5,  4, 1, 4, 0};
      vecs[10] = '{5'd16, 1'b0, {128{1'b1}},                          0, 1, 33, 16,  0, 1, 0, 0};
      v_after_rst = '{5'd1, 1'b0, 128'h33,                            0, 0,  3,  1,  0, 1, 0, 0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_mem_en", int'(mem_en), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_zero_count", int'(zero_count), 0);
      chk("rst_found_nz", int'(found_nz), 0);
      chk("rst_first_nz_idx", int'(first_nz_idx), 0);
      chk("rst_all_zero", int'(all_zero), 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset mid-scan, asserted during CHECK of word 1
      @(negedge clk);
      cur_data = 128'h11;
      start = 1'b1;
      len   = 5'd4;
      stop  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("mid_pre_busy", int'(busy), 1);
      chk("mid_pre_found_nz", int'(found_nz), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_outputs",
          int'({mem_en, mem_addr, busy, done, zero_count, found_nz, first_nz_idx, all_zero}), 0);
      @(negedge clk);
      chk("mid_rst_held_done", int'(done), 0);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("mid_post_quiet_%0d", c), int'({done, busy, mem_en}), 0);
      end
      run_vec(11, v_after_rst);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
